// File: rtl/mem_access_stage.sv
//------------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage of the 16-bit pipelined processor. Takes EX/MEM results,
// runs loads and stores over a single-request handshake with variable wait
// states, stalls the earlier stages while an access is outstanding, and loads
// the MEM/WB pipeline register that feeds the write-back mux.
//
// Optional feature (compile-time macro): MEM_TIMEOUT_EN
//   Defined   : an outstanding access aborts after TimeoutCycles wait cycles,
//               retires with RegWrite = 0 and sets the sticky MemErr flag.
//   Undefined : no wait counter, MemErr tied to 0, REQ waits indefinitely.
//
// Ports
//   Clk, Reset_n          clock (rising edge), async active-low reset
//   ExValid .. RegWriteIn EX/MEM inputs (valid, address/result, store data,
//                         destination, load/store, write-back controls)
//   Stall                 holds EX/MEM and earlier stages (combinational)
//   MemReq .. MemWData    memory request channel (held stable while waiting)
//   MemReady, MemRData    memory completion and read data
//   WbValid .. WriteReg   MEM/WB pipeline register
//   MemErr                sticky access-timeout flag
//------------------------------------------------------------------------------
module mem_access_stage #(
    parameter int RegWidth      = 16,
    parameter int RegAddrWidth  = 3,
    parameter int TimeoutCycles = 15
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    ExValid,
    input  logic [RegWidth-1:0]     ALUResult,
    input  logic [RegWidth-1:0]     StoreData,
    input  logic [RegAddrWidth-1:0] WriteRegIn,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic                    MemtoRegIn,
    input  logic                    RegWriteIn,
    output logic                    Stall,
    output logic                    MemReq,
    output logic                    MemWe,
    output logic [RegWidth-1:0]     MemAddr,
    output logic [RegWidth-1:0]     MemWData,
    input  logic                    MemReady,
    input  logic [RegWidth-1:0]     MemRData,
    output logic                    WbValid,
    output logic [RegWidth-1:0]     MemOut,
    output logic [RegWidth-1:0]     ALUOut,
    output logic                    MemtoReg,
    output logic                    RegWrite,
    output logic [RegAddrWidth-1:0] WriteReg,
    output logic                    MemErr
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } stateT;

    stateT state;
    stateT stateNext;

    // Decoded events for the current cycle, consumed by the datapath registers.
    logic acceptMem;    // memory op accepted in IDLE
    logic acceptAlu;    // non-memory instruction passes straight through
    logic complete;     // memory signalled completion while in REQ
    logic abortAccess;  // wait budget exhausted without completion
    logic timeoutHit;

    // Fields of the accepted memory op; the address lives in MemAddr.
    logic                    capIsLoad;
    logic                    capRegWrite;
    logic                    capMemtoReg;
    logic [RegAddrWidth-1:0] capWriteReg;

    //--------------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks below use blocking (=).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    //--------------------------------------------------------------------------
    // FSM next-state and event decode
    //--------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        stateNext   = state;
        Stall       = 1'b0;
        acceptMem   = 1'b0;
        acceptAlu   = 1'b0;
        complete    = 1'b0;
        abortAccess = 1'b0;
        case (state)
            IDLE: begin
                // MemReady is ignored here: no request is outstanding.
                if (ExValid) begin
                    if (MemRead || MemWrite) begin
                        acceptMem = 1'b1;
                        Stall     = 1'b1;
                        stateNext = REQ;
                    end else begin
                        acceptAlu = 1'b1;
                    end
                end
            end
            REQ: begin
                // Completion wins over a timeout landing on the same edge.
                // Stall releases on the finishing cycle so EX/MEM advances
                // past the memory op exactly once.
                if (MemReady) begin
                    complete  = 1'b1;
                    stateNext = IDLE;
                end else if (timeoutHit) begin
                    abortAccess = 1'b1;
                    stateNext   = IDLE;
                end else begin
                    Stall = 1'b1;
                end
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Optional access timeout
    //--------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam int CntWidth = $clog2(TimeoutCycles + 1);

    logic [CntWidth-1:0] waitCnt;

    // The count reaches TimeoutCycles on the edge that ends the last allowed
    // wait cycle, so abort is decided one count earlier.
    assign timeoutHit = (state == REQ) && (waitCnt == CntWidth'(TimeoutCycles - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            waitCnt <= '0;
            MemErr  <= 1'b0;
        end else begin
            if (acceptMem) begin
                waitCnt <= '0;
            end else if (state == REQ && !MemReady) begin
                waitCnt <= waitCnt + CntWidth'(1);
            end
            if (abortAccess) begin
                MemErr <= 1'b1;
            end
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign MemErr     = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // Memory request channel and captured op
    //--------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            MemReq      <= 1'b0;
            MemWe       <= 1'b0;
            MemAddr     <= '0;
            MemWData    <= '0;
            capIsLoad   <= 1'b0;
            capRegWrite <= 1'b0;
            capMemtoReg <= 1'b0;
            capWriteReg <= '0;
        end else if (acceptMem) begin
            MemReq      <= 1'b1;
            MemWe       <= MemWrite;
            MemAddr     <= ALUResult;
            MemWData    <= StoreData;
            // Read+write together is a store and must not write a register.
            capIsLoad   <= MemRead & ~MemWrite;
            capRegWrite <= RegWriteIn & ~(MemRead & MemWrite);
            capMemtoReg <= MemtoRegIn;
            capWriteReg <= WriteRegIn;
        end else if (complete || abortAccess) begin
            MemReq <= 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // MEM/WB pipeline register
    //--------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            WbValid  <= 1'b0;
            MemOut   <= '0;
            ALUOut   <= '0;
            MemtoReg <= 1'b0;
            RegWrite <= 1'b0;
            WriteReg <= '0;
        end else if (acceptAlu) begin
            WbValid  <= 1'b1;
            ALUOut   <= ALUResult;
            MemOut   <= '0;
            MemtoReg <= MemtoRegIn;
            RegWrite <= RegWriteIn;
            WriteReg <= WriteRegIn;
        end else if (complete || abortAccess) begin
            // An aborted access retires so the pipeline keeps moving, but it
            // carries no load data and never writes the register file.
            WbValid  <= 1'b1;
            ALUOut   <= MemAddr;
            MemOut   <= (complete && capIsLoad) ? MemRData : '0;
            MemtoReg <= capMemtoReg;
            RegWrite <= complete & capRegWrite;
            WriteReg <= capWriteReg;
        end else begin
            // Bubble: invalidate and kill the write, other fields hold.
            WbValid  <= 1'b0;
            RegWrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
//------------------------------------------------------------------------------
// tb_mem_access_stage
//
// Self-checking bench for mem_access_stage. The bench acts as the upstream
// pipeline (holds the instruction while a memory op is outstanding) and as the
// memory (decides the number of wait states per access). Expected write-back
// records come from a directed table or from a spec-level reference function.
//------------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int RW = 16;
    localparam int AW = 3;
    localparam int TO = 15;

    logic          Clk;
    logic          Reset_n;
    logic          ExValid;
    logic [RW-1:0] ALUResult;
    logic [RW-1:0] StoreData;
    logic [AW-1:0] WriteRegIn;
    logic          MemRead;
    logic          MemWrite;
    logic          MemtoRegIn;
    logic          RegWriteIn;
    logic          Stall;
    logic          MemReq;
    logic          MemWe;
    logic [RW-1:0] MemAddr;
    logic [RW-1:0] MemWData;
    logic          MemReady;
    logic [RW-1:0] MemRData;
    logic          WbValid;
    logic [RW-1:0] MemOut;
    logic [RW-1:0] ALUOut;
    logic          MemtoReg;
    logic          RegWrite;
    logic [AW-1:0] WriteReg;
    logic          MemErr;

    mem_access_stage #(
        .RegWidth      (RW),
        .RegAddrWidth  (AW),
        .TimeoutCycles (TO)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ExValid    (ExValid),
        .ALUResult  (ALUResult),
        .StoreData  (StoreData),
        .WriteRegIn (WriteRegIn),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoRegIn (MemtoRegIn),
        .RegWriteIn (RegWriteIn),
        .Stall      (Stall),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemReady   (MemReady),
        .MemRData   (MemRData),
        .WbValid    (WbValid),
        .MemOut     (MemOut),
        .ALUOut     (ALUOut),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .MemErr     (MemErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One instruction as presented by EX/MEM, plus the memory's behaviour for it.
    typedef struct packed {
        logic          exValid;
        logic          memRead;
        logic          memWrite;
        logic          regWriteIn;
        logic          memtoRegIn;
        logic [AW-1:0] writeReg;
        logic [RW-1:0] alu;
        logic [RW-1:0] storeData;
        logic [RW-1:0] rdata;
        int            waits;
    } instrT;

    typedef struct packed {
        logic          wbValid;
        logic [RW-1:0] memOut;
        logic [RW-1:0] aluOut;
        logic          memtoReg;
        logic          regWrite;
        logic [AW-1:0] writeReg;
    } wbT;

    typedef struct packed {
        instrT in;
        wbT    exp;
    } vecT;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // What MEM/WB should hold once an instruction retires, from the stage's
    // rules: loads return read data, stores and ALU ops return 0, read+write
    // is a store that never writes a register, invalid slots are bubbles.
    function automatic wbT refModel(input instrT i);
        wbT r;
        r = '0;
        if (i.exValid) begin
            r.wbValid  = 1'b1;
            r.aluOut   = i.alu;
            r.memtoReg = i.memtoRegIn;
            r.writeReg = i.writeReg;
            r.regWrite = i.regWriteIn && !(i.memRead && i.memWrite);
            r.memOut   = (i.memRead && !i.memWrite) ? i.rdata : '0;
        end
        return r;
    endfunction

    function automatic instrT randInstr();
        instrT i;
        int    kind;
        kind         = $urandom_range(0, 4);
        i            = '0;
        i.exValid    = (kind != 0);
        i.memRead    = (kind == 2 || kind == 4) || (kind == 0 && $urandom_range(0, 1) == 1);
        i.memWrite   = (kind == 3 || kind == 4);
        i.regWriteIn = 1'($urandom_range(0, 1));
        i.memtoRegIn = 1'($urandom_range(0, 1));
        i.writeReg   = AW'($urandom_range(0, 7));
        i.alu        = RW'($urandom);
        i.storeData  = RW'($urandom);
        i.rdata      = RW'($urandom);
        i.waits      = $urandom_range(0, 4);
        return i;
    endfunction

    task automatic checkWb(input string tag, input wbT e);
        check({tag, "_wbvalid"}, WbValid, e.wbValid);
        check({tag, "_regwrite"}, RegWrite, e.regWrite);
        if (e.wbValid) begin
            check({tag, "_memout"}, MemOut, e.memOut);
            check({tag, "_aluout"}, ALUOut, e.aluOut);
            check({tag, "_memtoreg"}, MemtoReg, e.memtoReg);
            check({tag, "_writereg"}, WriteReg, e.writeReg);
        end
        check({tag, "_memreq_idle"}, MemReq, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_wbvalid"}, WbValid, 1'b0);
        check({tag, "_memout"}, MemOut, '0);
        check({tag, "_aluout"}, ALUOut, '0);
        check({tag, "_memtoreg"}, MemtoReg, 1'b0);
        check({tag, "_regwrite"}, RegWrite, 1'b0);
        check({tag, "_writereg"}, WriteReg, '0);
        check({tag, "_memreq"}, MemReq, 1'b0);
        check({tag, "_memwe"}, MemWe, 1'b0);
        check({tag, "_memaddr"}, MemAddr, '0);
        check({tag, "_memwdata"}, MemWData, '0);
        check({tag, "_memerr"}, MemErr, 1'b0);
    endtask

    task automatic drive(input instrT i);
        ExValid    = i.exValid;
        MemRead    = i.memRead;
        MemWrite   = i.memWrite;
        RegWriteIn = i.regWriteIn;
        MemtoRegIn = i.memtoRegIn;
        WriteRegIn = i.writeReg;
        ALUResult  = i.alu;
        StoreData  = i.storeData;
    endtask

    // Called at a negedge; returns at the negedge after the instruction's
    // retirement edge, so consecutive calls present instructions back-to-back.
    task automatic runInstr(input string tag, input instrT i, input wbT e);
        bit isMem;
        isMem = i.exValid && (i.memRead || i.memWrite);
        drive(i);
        MemReady = 1'($urandom_range(0, 1));  // must be ignored outside REQ
        MemRData = RW'($urandom);
        #1 check({tag, "_stall_accept"}, Stall, isMem);
        if (isMem) begin
            for (int k = 0; k <= i.waits; k++) begin
                @(negedge Clk);
                check({tag, "_memreq"}, MemReq, 1'b1);
                check({tag, "_memaddr"}, MemAddr, i.alu);
                check({tag, "_memwdata"}, MemWData, i.storeData);
                check({tag, "_memwe"}, MemWe, i.memWrite);
                check({tag, "_wb_bubble"}, WbValid, 1'b0);
                MemReady = (k == i.waits);
                MemRData = (k == i.waits) ? i.rdata : RW'($urandom);
                #1 check({tag, "_stall_req"}, Stall, (k != i.waits));
            end
        end
        @(negedge Clk);
        checkWb(tag, e);
        check({tag, "_memerr"}, MemErr, 1'b0);
    endtask

    vecT vecs[7];

    initial begin
        instrT ri;

        // Directed vectors: ALU op, zero-wait load, 3-wait store followed by
        // an ALU op, bubble, read+write treated as store, 2-wait load.
        vecs[0] = '{in: '{1, 0, 0, 1, 0, 3'd5, 16'hFFDF, 16'h0000, 16'h0000, 0},
                    exp: '{1, 16'h0000, 16'hFFDF, 0, 1, 3'd5}};
        vecs[1] = '{in: '{1, 1, 0, 1, 1, 3'd2, 16'h0010, 16'h0000, 16'd45, 0},
                    exp: '{1, 16'd45, 16'h0010, 1, 1, 3'd2}};
        vecs[2] = '{in: '{1, 0, 1, 0, 0, 3'd0, 16'h0020, 16'd100, 16'h0000, 3},
                    exp: '{1, 16'h0000, 16'h0020, 0, 0, 3'd0}};
        vecs[3] = '{in: '{1, 0, 0, 1, 0, 3'd3, 16'h1234, 16'h0000, 16'h0000, 0},
                    exp: '{1, 16'h0000, 16'h1234, 0, 1, 3'd3}};
        vecs[4] = '{in: '{0, 0, 0, 1, 0, 3'd1, 16'h5555, 16'h0000, 16'h0000, 0},
                    exp: '{0, 16'h0000, 16'h0000, 0, 0, 3'd0}};
        vecs[5] = '{in: '{1, 1, 1, 1, 1, 3'd6, 16'h0300, 16'hBEEF, 16'hAAAA, 1},
                    exp: '{1, 16'h0000, 16'h0300, 1, 0, 3'd6}};
        vecs[6] = '{in: '{1, 1, 0, 1, 1, 3'd7, 16'hFFFE, 16'h0000, 16'hFFFF, 2},
                    exp: '{1, 16'hFFFF, 16'hFFFE, 1, 1, 3'd7}};

        Reset_n = 1'b0;
        drive('0);
        MemReady = 1'b0;
        MemRData = '0;
        repeat (2) @(negedge Clk);
        checkAllZero("reset");
        Reset_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            runInstr($sformatf("vec%0d", v), vecs[v].in, vecs[v].exp);
        end

        // Reset while a load to 0x0040 is waiting on memory.
        ri          = '0;
        ri.exValid  = 1'b1;
        ri.memRead  = 1'b1;
        ri.regWriteIn = 1'b1;
        ri.alu      = 16'h0040;
        drive(ri);
        MemReady = 1'b0;
        @(negedge Clk);
        check("rstreq_memreq_before", MemReq, 1'b1);
        #2 Reset_n = 1'b0;
        drive('0);
        #1 checkAllZero("rstreq_async");
        @(negedge Clk);
        Reset_n  = 1'b1;
        MemReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            check("rstreq_no_wb", WbValid, 1'b0);
            check("rstreq_no_req", MemReq, 1'b0);
        end
        MemReady = 1'b0;
        // The FSM must be in IDLE: an ALU op retires in one cycle.
        runInstr("rstreq_alu", vecs[3].in, vecs[3].exp);

        // Randomized stream against the reference model.
        for (int n = 0; n < 300; n++) begin
            ri = randInstr();
            runInstr("rand", ri, refModel(ri));
        end

`ifdef MEM_TIMEOUT_EN
        // Load with memory never answering: abort after exactly TO REQ cycles.
        ri            = '0;
        ri.exValid    = 1'b1;
        ri.memRead    = 1'b1;
        ri.regWriteIn = 1'b1;
        ri.writeReg   = 3'd4;
        ri.alu        = 16'h0080;
        drive(ri);
        MemReady = 1'b0;
        #1 check("to_stall_accept", Stall, 1'b1);
        for (int k = 1; k <= TO; k++) begin
            @(negedge Clk);
            check("to_memreq", MemReq, 1'b1);
            check("to_wb_bubble", WbValid, 1'b0);
            check("to_memerr_pending", MemErr, 1'b0);
            if (k < TO) begin
                #1 check("to_stall_wait", Stall, 1'b1);
            end
        end
        @(negedge Clk);
        check("to_wbvalid", WbValid, 1'b1);
        check("to_regwrite", RegWrite, 1'b0);
        check("to_memreq_drop", MemReq, 1'b0);
        check("to_memerr", MemErr, 1'b1);
        drive('0);
        repeat (3) @(negedge Clk);
        check("to_memerr_sticky", MemErr, 1'b1);

        // Same access with MemReady on the last allowed cycle completes.
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        ri.waits = TO - 1;
        ri.rdata = 16'h0BAD;
        runInstr("to_edge_ok", ri, refModel(ri));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the 16-bit pipelined processor, directly upstream of the write-back mux.
- Takes EX/MEM results and performs loads and stores over a single-request memory handshake with variable wait states.
- Stalls earlier stages while an access is outstanding.
- Registers MemOut, ALUOut, MemtoReg, RegWrite and the destination register into the MEM/WB pipeline register that feeds write-back.

Parameters:
- RegWidth, 16, data and address width.
- RegAddrWidth, 3, register-file index width.
- TimeoutCycles, 15, wait cycles before abort (used only with MEM_TIMEOUT_EN); width of the wait counter is ceil(log2(TimeoutCycles+1)).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- ExValid  in  1  EX/MEM holds a valid instruction.
- ALUResult  in  RegWidth  ALU result; also the memory address.
- StoreData  in  RegWidth  store data.
- WriteRegIn  in  RegAddrWidth  destination register.
- MemRead  in  1  load.
- MemWrite  in  1  store.
- MemtoRegIn  in  1  write-back select.
- RegWriteIn  in  1  register write enable.
- Stall  out  1  hold EX/MEM and earlier stages.
- MemReq  out  1  memory request.
- MemWe  out  1  1 = write, 0 = read.
- MemAddr  out  RegWidth  request address.
- MemWData  out  RegWidth  request write data.
- MemReady  in  1  memory completes the current request (read data valid).
- MemRData  in  RegWidth  read data.
- WbValid  out  1  MEM/WB register holds a valid instruction.
- MemOut  out  RegWidth  loaded data to write-back.
- ALUOut  out  RegWidth  ALU result to write-back.
- MemtoReg  out  1  write-back select.
- RegWrite  out  1  register write enable.
- WriteReg  out  RegAddrWidth  destination register.
- MemErr  out  1  sticky access-timeout flag (0 when MEM_TIMEOUT_EN is undefined).

Behaviour:
- Reset (Reset_n = 0, asynchronous)
  - All registered outputs go to 0: WbValid, MemOut, ALUOut, MemtoReg, RegWrite, WriteReg, MemReq, MemWe, MemAddr, MemWData, MemErr.
  - FSM goes to IDLE.
  - An access in flight is abandoned with no write-back; memory must tolerate MemReq dropping.
- FSM states: IDLE, REQ.
- IDLE, ExValid = 1, no memory op:
  - At the next edge, load MEM/WB with ALUOut = ALUResult, MemOut = 0, MemtoReg/RegWrite/WriteReg from inputs, WbValid = 1.
  - Latency 1 cycle.
- IDLE, ExValid = 1, MemRead or MemWrite:
  - Stall = 1 combinationally.
  - At the next edge, capture the op and ALUResult; drive MemReq = 1, MemAddr = ALUResult, MemWData = StoreData, MemWe = MemWrite.
  - WbValid = 0 (bubble); move to REQ.
- IDLE, ExValid = 0: WbValid = 0 and RegWrite = 0 at the next edge; other MEM/WB fields hold.
- REQ:
  - MemReq, MemAddr, MemWData and MemWe are held stable.
  - Stall = !MemReady.
  - WbValid = 0 each cycle MemReady = 0.
- REQ with MemReady = 1 at an edge:
  - MemReq drops; MEM/WB loads WbValid = 1, ALUOut = captured address, MemOut = MemRData for loads or 0 for stores, plus the captured MemtoReg, RegWrite and WriteReg.
  - Return to IDLE.
  - Zero-wait load latency (op accepted to WbValid) is 2 cycles; each wait state adds 1.
- Back-to-back: Stall is 0 in the MemReady cycle, so the next instruction is accepted in IDLE on the following cycle; no instruction is lost or duplicated.
- MemRead and MemWrite both 1: treated as a store; captured RegWrite is forced to 0.
- MemReady while IDLE: ignored.
- The MEM/WB register updates every edge it is not in REQ-waiting; the downstream mux is combinational.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to REQ and increments each REQ cycle with MemReady = 0.
  - When it reaches TimeoutCycles, the access aborts at that edge: MemReq drops, WbValid = 1 with RegWrite forced to 0, MemErr set.
  - MemErr stays set until reset.
  - MemReady arriving on the abort edge takes priority: normal completion, no error.
- Undefined: no counter; MemErr tied to 0; REQ waits indefinitely.

Test Plan:
- Reset mid-REQ: load to 0x0040 pending, Reset_n pulsed low -> MemReq = 0, all outputs 0, FSM in IDLE immediately without waiting for Clk; no WbValid after release.
- ALU op: ExValid = 1, ALUResult = 0xFFDF (-33), RegWriteIn = 1, WriteRegIn = 5, MemtoRegIn = 0 -> next cycle WbValid = 1, ALUOut = 0xFFDF, MemOut = 0, RegWrite = 1, WriteReg = 5, Stall never 1.
- Zero-wait load: MemRead = 1, ALUResult = 0x0010, MemtoRegIn = 1, MemReady = 1 in the first REQ cycle with MemRData = 45 -> Stall high 1 cycle, MemAddr = 0x0010, MemWe = 0, WbValid 2 cycles after accept with MemOut = 45, MemtoReg = 1.
- Store with 3 wait states, then an ALU op: MemWrite = 1, StoreData = 100, ALUResult = 0x0020 -> MemReq held 4 cycles with MemWData = 100, MemWe = 1, Stall high 4 cycles, then WbValid = 1 with RegWrite = 0; ALU op WbValid on the following cycle, none dropped or duplicated.
- MEM_TIMEOUT_EN, TimeoutCycles = 15, MemReady never asserted -> abort exactly 15 REQ cycles after entry, MemErr = 1 and held, WbValid = 1 with RegWrite = 0; a repeat run with MemReady on the 15th cycle completes normally with MemErr = 0.
